dac_seg_encoder: RTL
====================

Name: dac_seg_encoder

Overview:
Digital front end that drives driver_cell. Accepts a linear DAC code over a valid/ready handshake and splits it into binary LSB controls plus thermometer MSB controls, each with an exact complement. Sequences driver_cell power-up and power-down through pdb, and forces zero code while the cell is settling.

Parameters:
BIN_W, 8, binary LSB width (datain/datainb)
THERM_W, 17, thermometer element count (datatherm/datathermb)
MSB_W, 5, width of the MSB field of code; must satisfy 2^MSB_W > THERM_W
WAKE_CYC, 4, cycles from pdb rising to code_ready (>=1)
SHUT_CYC, 2, cycles of forced zero code before pdb falls (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
en  in  1  power request; 1 = run driver_cell
code  in  BIN_W+MSB_W  DAC code; [BIN_W-1:0] binary, [top] MSB count m
code_valid  in  1  code present
code_ready  out  1  code accepted when code_valid && code_ready
pdb  out  1  driver_cell power-down bar
datain  out  BIN_W  binary control
datainb  out  BIN_W  complement of datain
datatherm  out  THERM_W  thermometer control
datathermb  out  THERM_W  complement of datatherm
dac_on  out  1  1 while in RUN
sat  out  1  sticky saturation flag
sat_clr  in  1  clears sat

Behaviour:
- All outputs registered except code_ready = (state==RUN) && en.
- Reset values: state OFF, pdb=0, datain=0, datainb=all 1, datatherm=0, datathermb=all 1, dac_on=0, sat=0, DEM pointer=0.
- Zero code: datain=0, datatherm=0, complements all 1.
- Invariant, every cycle including reset: datainb==~datain and datathermb==~datatherm.
- FSM:
  - OFF: pdb=0, zero code. en=1 -> WAKE.
  - WAKE: pdb=1 from the first WAKE cycle, zero code, counter loaded with WAKE_CYC-1 and decremented each cycle. Counter==0 -> RUN. en=0 -> SHUT.
  - RUN: pdb=1, dac_on=1. A handshake updates the outputs on the next edge (latency 1). With no handshake, outputs hold the last code. en=0 -> SHUT; zero code appears on the same edge.
  - SHUT: pdb=1, zero code, counter runs SHUT_CYC cycles, then -> OFF with pdb=0. en is ignored in SHUT. Re-power goes OFF -> WAKE, so OFF lasts at least 1 cycle.
- Encoding, with m = code[top] and b = code[BIN_W-1:0]:
  - m<=THERM_W: datain=b; datatherm bit i = (i<m).
  - m>THERM_W: saturate to full scale: datain=all 1, datatherm=all 1, sat<=1.
  - Full scale = THERM_W*2^BIN_W + 2^BIN_W-1 = 4607 by default.
- sat clears on sat_clr. If sat_clr and a saturating transfer occur in the same cycle, set wins.
- rst in any state: reset values on the next edge; any pending code is dropped.
- code_valid outside RUN: ignored, not buffered.

Optional Feature:
THERM_DEM_EN
- Defined: rotational dynamic element matching on the thermometer elements.
  - 5-bit pointer p, range 0..THERM_W-1.
  - On an accepted code with effective m, set bits (p+i) mod THERM_W for i<m, then p <= (p+m) mod THERM_W.
  - Saturation sets all bits; p is unchanged.
  - Popcount of datatherm is identical to the undefined case. Zero-code forcing does not move p.
- Undefined: fixed unary fill from bit 0; no pointer logic is built.

Test Plan:
1. rst=1 then en=0 for 5 cycles -> pdb=0, datain=8'h00, datainb=8'hFF, datatherm=17'h00000, datathermb=17'h1FFFF, code_ready=0.
2. en=1 at cycle 0 -> pdb=1 at edge 1, code_ready=1 and dac_on=1 exactly WAKE_CYC=4 cycles after WAKE entry; code_valid before that is ignored.
3. In RUN, code=13'h0CAA (m=12, b=AA) -> next cycle datain=8'hAA, datainb=8'h55, datatherm=17'h00FFF, datathermb=17'h1F000; values hold while code_valid=0.
4. code=13'h1FFF (m=31) -> datain=8'hFF, datatherm=17'h1FFFF, sat=1. Then sat_clr=1 -> sat=0. code=13'h1100 (m=17) -> datatherm=17'h1FFFF, sat stays 0.
5. en=0 in RUN -> zero code on the next edge, pdb=1 for SHUT_CYC=2 cycles then 0. Separately, rst mid-RUN -> reset values next edge.
6. THERM_DEM_EN defined: code 13'h0C00 twice -> first datatherm=17'h00FFF, second 17'h1F07F (p 0->12->7).

Source files
------------

// File: rtl/dac_seg_encoder.sv
// ============================================================================
// Module   : dac_seg_encoder
// Function : Front end for driver_cell. Splits a linear DAC code into binary
//            LSB controls and thermometer MSB controls, each with an exact
//            complement. Sequences driver_cell power-up and power-down through
//            pdb and forces zero code while the cell settles.
// Options  : define THERM_DEM_EN for rotational dynamic element matching on
//            the thermometer elements (default: fixed unary fill from bit 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_seg_encoder #(
  parameter int BIN_W    = 8,
  parameter int THERM_W  = 17,
  parameter int MSB_W    = 5,
  parameter int WAKE_CYC = 4,
  parameter int SHUT_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [BIN_W+MSB_W-1:0]   code,
  input  logic                     code_valid,
  output logic                     code_ready,
  output logic                     pdb,
  output logic [BIN_W-1:0]         datain,
  output logic [BIN_W-1:0]         datainb,
  output logic [THERM_W-1:0]       datatherm,
  output logic [THERM_W-1:0]       datathermb,
  output logic                     dac_on,
  output logic                     sat,
  input  logic                     sat_clr
);

  // Counter is shared by the wake-up and shut-down waits.
  localparam int c_CNT_MAX = (WAKE_CYC > SHUT_CYC) ? WAKE_CYC : SHUT_CYC;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_WAKE_LD = c_CNT_W'(WAKE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_SHUT_LD = c_CNT_W'(SHUT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [MSB_W-1:0]   c_THERM_M = MSB_W'(THERM_W);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_RUN  = 2'd2,
    ST_SHUT = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [MSB_W-1:0]     w_m;
  logic [BIN_W-1:0]     w_b;
  logic                 w_accept;
  logic                 w_sat;
  logic [THERM_W-1:0]   w_therm_enc;
  logic [BIN_W-1:0]     w_din_nxt;
  logic [THERM_W-1:0]   w_therm_nxt;

  assign w_m        = code[BIN_W+MSB_W-1:BIN_W];
  assign w_b        = code[BIN_W-1:0];
  assign code_ready = (r_state == ST_RUN) && en;
  assign w_accept   = code_valid && code_ready;
  // An MSB count beyond the element count cannot be represented: clamp.
  assign w_sat      = (w_m > c_THERM_M);

`ifdef THERM_DEM_EN
  localparam int c_PTR_W = (THERM_W > 1) ? $clog2(THERM_W) : 1;
  localparam logic [c_PTR_W:0] c_THERM_P = (c_PTR_W+1)'(THERM_W);

  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W:0]     w_ptr_sum;
  logic [c_PTR_W-1:0]   w_ptr_nxt;

  // Rotated unary fill: element j is on when its distance from the pointer
  // (modulo THERM_W) is below the MSB count.
  always_comb begin
    w_therm_enc = '0;
    for (int j = 0; j < THERM_W; j++) begin
      if (j >= int'(r_ptr))
        w_therm_enc[j] = ((j - int'(r_ptr)) < int'(w_m));
      else
        w_therm_enc[j] = ((j + THERM_W - int'(r_ptr)) < int'(w_m));
    end
  end

  // Pointer advance by m, wrapped once; m never exceeds THERM_W here.
  assign w_ptr_sum = {1'b0, r_ptr} + (c_PTR_W+1)'(w_m);
  assign w_ptr_nxt = (w_ptr_sum >= c_THERM_P) ? c_PTR_W'(w_ptr_sum - c_THERM_P)
                                              : c_PTR_W'(w_ptr_sum);

  // Pointer moves only on accepted, non-saturating codes.
  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_accept && !w_sat)
      r_ptr <= w_ptr_nxt;
  end
`else
  // Fixed unary fill from element 0.
  always_comb begin
    w_therm_enc = '0;
    for (int i = 0; i < THERM_W; i++)
      w_therm_enc[i] = (MSB_W'(i) < w_m);
  end
`endif

  assign w_din_nxt   = w_sat ? '1 : w_b;
  assign w_therm_nxt = w_sat ? '1 : w_therm_enc;

  // Power sequencing FSM with registered pdb, dac_on and data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_cnt      <= '0;
      pdb        <= 1'b0;
      dac_on     <= 1'b0;
      datain     <= '0;
      datainb    <= '1;
      datatherm  <= '0;
      datathermb <= '1;
    end else begin
      case (r_state)
        ST_OFF: begin
          pdb        <= 1'b0;
          dac_on     <= 1'b0;
          datain     <= '0;
          datainb    <= '1;
          datatherm  <= '0;
          datathermb <= '1;
          if (en) begin
            r_state <= ST_WAKE;
            pdb     <= 1'b1;
            r_cnt   <= c_WAKE_LD;
          end
        end
        ST_WAKE: begin
          datain     <= '0;
          datainb    <= '1;
          datatherm  <= '0;
          datathermb <= '1;
          if (!en) begin
            r_state <= ST_SHUT;
            r_cnt   <= c_SHUT_LD;
          end else if (r_cnt == '0) begin
            r_state <= ST_RUN;
            dac_on  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!en) begin
            // Zero code lands on the same edge as the exit from RUN.
            r_state    <= ST_SHUT;
            r_cnt      <= c_SHUT_LD;
            dac_on     <= 1'b0;
            datain     <= '0;
            datainb    <= '1;
            datatherm  <= '0;
            datathermb <= '1;
          end else if (w_accept) begin
            datain     <= w_din_nxt;
            datainb    <= ~w_din_nxt;
            datatherm  <= w_therm_nxt;
            datathermb <= ~w_therm_nxt;
          end
        end
        ST_SHUT: begin
          datain     <= '0;
          datainb    <= '1;
          datatherm  <= '0;
          datathermb <= '1;
          if (r_cnt == '0) begin
            r_state <= ST_OFF;
            pdb     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_state    <= ST_OFF;
          pdb        <= 1'b0;
          dac_on     <= 1'b0;
          datain     <= '0;
          datainb    <= '1;
          datatherm  <= '0;
          datathermb <= '1;
        end
      endcase
    end
  end

  // Sticky saturation flag; a saturating transfer beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)
      sat <= 1'b0;
    else if (w_accept && w_sat)
      sat <= 1'b1;
    else if (sat_clr)
      sat <= 1'b0;
  end

endmodule

`default_nettype wire
